// File: rtl/if_fetch.sv
// if_fetch: owns the PC, issues instruction fetches, queues returned
// instructions in order for decode, and flushes on execute redirects.
module if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc,
    output logic        fetch_idle
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = 8;

    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [DW-1:0] D_ONE  = DW'(1);

    logic             run_q;
    logic [63:0]      pc_q, pc_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    fptr_q, fptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    drop_q, drop_d;
    logic [DEPTH-1:0] alloc_q, alloc_d;
    logic [DEPTH-1:0] fill_q, fill_d;
    logic [63:0]      spc_q [DEPTH];
    logic [63:0]      spc_d [DEPTH];
    logic [31:0]      sinst_q [DEPTH];
    logic [31:0]      sinst_d [DEPTH];

    logic [CW-1:0]    pend;
    logic [DW-1:0]    drop_sum;
    logic             push, pop, fill_hit;

    // Slots whose request is out but whose data has not come back yet
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_q[i] && !fill_q[i]) begin
                pend = pend + C_ONE;
            end
        end
    end

    assign imem_req_valid = run_q && !redirect_valid && (cnt_q < C_FULL);
    assign imem_req_addr  = pc_q;

    assign id_valid   = !redirect_valid && alloc_q[head_q] && fill_q[head_q];
    assign id_inst    = sinst_q[head_q];
    assign id_pc      = spc_q[head_q];
    assign fetch_idle = (drop_q == '0) && (cnt_q == '0);

    assign push     = imem_req_valid && imem_req_ready;
    assign pop      = id_valid && id_ready;
    assign fill_hit = imem_resp_valid && (drop_q == '0) &&
                      alloc_q[fptr_q] && !fill_q[fptr_q];

    always_comb begin
        pc_d     = pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        fptr_d   = fptr_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        alloc_d  = alloc_q;
        fill_d   = fill_q;
        spc_d    = spc_q;
        sinst_d  = sinst_q;
        drop_sum = drop_q + DW'(pend);
        if (redirect_valid) begin
            pc_d    = {redirect_pc[63:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            fptr_d  = '0;
            cnt_d   = '0;
            alloc_d = '0;
            fill_d  = '0;
            // A response landing now belongs to a flushed slot
            if (imem_resp_valid && drop_sum != '0) begin
                drop_d = drop_sum - D_ONE;
            end else begin
                drop_d = drop_sum;
            end
        end else begin
            if (pop) begin
                alloc_d[head_q] = 1'b0;
                fill_d[head_q]  = 1'b0;
                head_d          = head_q + P_ONE;
            end
            if (imem_resp_valid && drop_q != '0) begin
                drop_d = drop_q - D_ONE;
            end else if (fill_hit) begin
                fill_d[fptr_q]  = 1'b1;
                sinst_d[fptr_q] = imem_resp_data;
                fptr_d          = fptr_q + P_ONE;
            end
            if (push) begin
                alloc_d[tail_q] = 1'b1;
                fill_d[tail_q]  = 1'b0;
                spc_d[tail_q]   = pc_q;
                tail_d          = tail_q + P_ONE;
                pc_d            = pc_q + 64'd4;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + C_ONE;
            end else if (pop && !push) begin
                cnt_d = cnt_q - C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            pc_q    <= {RESET_PC[63:2], 2'b00};
            head_q  <= '0;
            tail_q  <= '0;
            fptr_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            alloc_q <= '0;
            fill_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                spc_q[i]   <= '0;
                sinst_q[i] <= '0;
            end
        end else begin
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fptr_q  <= fptr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            spc_q   <= spc_d;
            sinst_q <= sinst_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: in-order memory with per-request latency and a
// sequential-PC reference for the request and decode streams.
module tb_if_fetch;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        fetch_idle;

    if_fetch #(.RESET_PC(BASE), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .fetch_idle      (fetch_idle)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int lat = 0;
    int alloc_m = 0;
    int gate_err = 0;
    int idle_err = 0;
    bit live = 0;
    bit arm = 0;
    bit fired = 0;
    logic [63:0] arm_pc;

    logic [63:0] mq_addr[$];
    int          mq_due[$];
    logic [63:0] req_log[$];
    int          req_cyc[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    int          pop_cyc[$];

    function automatic logic [31:0] mem_of(input logic [63:0] a);
        return ~a[31:0] ^ {a[47:32], 16'h0000};
    endfunction

    task automatic clear_logs();
        req_log.delete();
        req_cyc.delete();
        pop_pc.delete();
        pop_inst.delete();
        pop_cyc.delete();
    endtask

    // One clock: memory responds, handshakes are logged, model counts advance
    task automatic cycle();
        bit idle_exp;
        bit vexp;
        if (fired) begin
            redirect_valid = 1'b0;
            fired = 1'b0;
        end
        idle_exp = (mq_addr.size() == 0) && (alloc_m == 0);
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_of(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        if (arm && imem_resp_valid) begin
            redirect_valid = 1'b1;
            redirect_pc    = arm_pc;
            arm   = 1'b0;
            fired = 1'b1;
        end
        #1;
        vexp = live && !redirect_valid && (alloc_m < DEPTH);
        if (imem_req_valid !== vexp) gate_err++;
        if (fetch_idle !== idle_exp) idle_err++;
        if (redirect_valid) alloc_m = 0;
        if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            req_cyc.push_back(cyc);
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + 1 + lat);
            alloc_m++;
        end
        if (id_valid && id_ready) begin
            pop_pc.push_back(id_pc);
            pop_inst.push_back(id_inst);
            pop_cyc.push_back(cyc);
            alloc_m--;
        end
        @(posedge clk);
        if (rst_n) live = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        arm   = 1'b0;
        fired = 1'b0;
        lat   = 0;
        mq_addr.delete();
        mq_due.delete();
        alloc_m = 0;
        live    = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        cycle();
        ncmp++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        ncmp++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
        ncmp++; if (id_inst !== 32'h0) begin nerr++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
        ncmp++; if (id_pc !== 64'h0) begin nerr++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
        ncmp++; if (fetch_idle !== 1'b1) begin nerr++; $display("FAIL reset_idle got %b want 1", fetch_idle); end
        ncmp++; if (imem_req_addr !== BASE) begin nerr++; $display("FAIL reset_addr got %h want %h", imem_req_addr, BASE); end
        rst_n = 1'b1;
        #1;
        ncmp++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL release_req_valid got %b want 0", imem_req_valid); end
        cycle();
        ncmp++; if (imem_req_valid !== 1'b1) begin nerr++; $display("FAIL first_edge_req_valid got %b want 1", imem_req_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 20; i++) cycle();
        ncmp++; if (req_log.size() < 8) begin nerr++; $display("FAIL stream_req_count got %0d want >=8", req_log.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            ncmp++; if (req_log[i] !== BASE + 64'(4 * i)) begin nerr++; $display("FAIL stream_req[%0d] got %h want %h", i, req_log[i], BASE + 64'(4 * i)); end
        end
        ncmp++; if (pop_pc.size() < 6) begin nerr++; $display("FAIL stream_pop_count got %0d want >=6", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            ncmp++; if (pop_pc[i] !== BASE + 64'(4 * i)) begin nerr++; $display("FAIL stream_pc[%0d] got %h want %h", i, pop_pc[i], BASE + 64'(4 * i)); end
            ncmp++; if (pop_inst[i] !== mem_of(BASE + 64'(4 * i))) begin nerr++; $display("FAIL stream_inst[%0d] got %h want %h", i, pop_inst[i], mem_of(BASE + 64'(4 * i))); end
        end
        if (pop_cyc.size() > 0 && req_cyc.size() > 0) begin
            ncmp++; if (pop_cyc[0] !== req_cyc[0] + 2) begin nerr++; $display("FAIL stream_latency got %0d want %0d", pop_cyc[0] - req_cyc[0], 2); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        id_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        ncmp++; if (req_log.size() !== DEPTH) begin nerr++; $display("FAIL bp_req_count got %0d want %0d", req_log.size(), DEPTH); end
        ncmp++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL bp_req_valid got %b want 0", imem_req_valid); end
        ncmp++; if (id_valid !== 1'b1) begin nerr++; $display("FAIL bp_id_valid got %b want 1", id_valid); end
        ncmp++; if (id_pc !== BASE) begin nerr++; $display("FAIL bp_id_pc got %h want %h", id_pc, BASE); end
        ncmp++; if (id_inst !== mem_of(BASE)) begin nerr++; $display("FAIL bp_id_inst got %h want %h", id_inst, mem_of(BASE)); end
        id_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        ncmp++; if (pop_pc.size() < 4) begin nerr++; $display("FAIL bp_pop_count got %0d want >=4", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            ncmp++; if (pop_pc[i] !== BASE + 64'(4 * i)) begin nerr++; $display("FAIL bp_pc[%0d] got %h want %h", i, pop_pc[i], BASE + 64'(4 * i)); end
        end
    endtask

    task automatic test_redirect_drop();
        logic [63:0] tgt;
        int b;
        tgt = 64'h0000_0000_8000_1000;
        do_reset();
        lat = 3;
        for (int i = 0; i < 10 && req_log.size() < 2; i++) cycle();
        ncmp++; if (req_log.size() !== 2) begin nerr++; $display("FAIL rd_outstanding got %0d want 2", req_log.size()); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1002;
        cycle();
        redirect_valid = 1'b0;
        lat = 0;
        #1;
        ncmp++; if (imem_req_valid !== 1'b1) begin nerr++; $display("FAIL rd_req_valid got %b want 1", imem_req_valid); end
        ncmp++; if (imem_req_addr !== tgt) begin nerr++; $display("FAIL rd_req_addr got %h want %h", imem_req_addr, tgt); end
        b = req_log.size();
        for (int i = 0; i < 15; i++) cycle();
        for (int i = b; i < req_log.size(); i++) begin
            ncmp++; if (req_log[i] !== tgt + 64'(4 * (i - b))) begin nerr++; $display("FAIL rd_req[%0d] got %h want %h", i, req_log[i], tgt + 64'(4 * (i - b))); end
        end
        ncmp++; if (pop_pc.size() < 1) begin nerr++; $display("FAIL rd_pop_count got %0d want >=1", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            ncmp++; if (pop_pc[i] !== tgt + 64'(4 * i)) begin nerr++; $display("FAIL rd_pc[%0d] got %h want %h", i, pop_pc[i], tgt + 64'(4 * i)); end
            ncmp++; if (pop_inst[i] !== mem_of(tgt + 64'(4 * i))) begin nerr++; $display("FAIL rd_inst[%0d] got %h want %h", i, pop_inst[i], mem_of(tgt + 64'(4 * i))); end
        end
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        ncmp++; if (fetch_idle !== 1'b1) begin nerr++; $display("FAIL rd_idle got %b want 1", fetch_idle); end
    endtask

    task automatic test_redirect_same_cycle();
        logic [63:0] tgt;
        tgt = 64'h0000_0000_8000_2000;
        do_reset();
        lat = 2;
        id_ready = 1'b0;
        arm = 1'b1;
        arm_pc = tgt;
        for (int i = 0; i < 8; i++) cycle();
        id_ready = 1'b1;
        lat = 0;
        for (int i = 0; i < 15; i++) cycle();
        ncmp++; if (req_log.size() < 3) begin nerr++; $display("FAIL sc_req_count got %0d want >=3", req_log.size()); end
        else begin
            ncmp++; if (req_log[2] !== tgt) begin nerr++; $display("FAIL sc_first_req got %h want %h", req_log[2], tgt); end
        end
        ncmp++; if (pop_pc.size() < 1) begin nerr++; $display("FAIL sc_pop_count got %0d want >=1", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            ncmp++; if (pop_pc[i] !== tgt + 64'(4 * i)) begin nerr++; $display("FAIL sc_pc[%0d] got %h want %h", i, pop_pc[i], tgt + 64'(4 * i)); end
            ncmp++; if (pop_inst[i] !== mem_of(tgt + 64'(4 * i))) begin nerr++; $display("FAIL sc_inst[%0d] got %h want %h", i, pop_inst[i], mem_of(tgt + 64'(4 * i))); end
        end
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        ncmp++; if (fetch_idle !== 1'b1) begin nerr++; $display("FAIL sc_idle got %b want 1", fetch_idle); end
    endtask

    task automatic test_req_stall();
        logic [63:0] tgt;
        tgt = 64'h0000_0000_8000_0100;
        do_reset();
        imem_req_ready = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            ncmp++; if (imem_req_addr !== BASE || imem_req_valid !== 1'b1) begin nerr++; $display("FAIL stall_addr[%0d] got %h/%b want %h/1", i, imem_req_addr, imem_req_valid, BASE); end
            cycle();
        end
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        #1;
        ncmp++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL stall_withdraw got %b want 0", imem_req_valid); end
        cycle();
        redirect_valid = 1'b0;
        #1;
        ncmp++; if (imem_req_addr !== tgt) begin nerr++; $display("FAIL stall_new_addr got %h want %h", imem_req_addr, tgt); end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        ncmp++; if (req_log.size() < 1 || req_log[0] !== tgt) begin nerr++; $display("FAIL stall_first_req got %h want %h", (req_log.size() > 0) ? req_log[0] : 64'h0, tgt); end
        ncmp++; if (pop_pc.size() < 1 || pop_pc[0] !== tgt) begin nerr++; $display("FAIL stall_first_pop got %h want %h", (pop_pc.size() > 0) ? pop_pc[0] : 64'h0, tgt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        lat = 3;
        for (int i = 0; i < 8; i++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        ncmp++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL ar_req_valid got %b want 0", imem_req_valid); end
        ncmp++; if (id_valid !== 1'b0) begin nerr++; $display("FAIL ar_id_valid got %b want 0", id_valid); end
        ncmp++; if (id_pc !== 64'h0) begin nerr++; $display("FAIL ar_id_pc got %h want 0", id_pc); end
        ncmp++; if (id_inst !== 32'h0) begin nerr++; $display("FAIL ar_id_inst got %h want 0", id_inst); end
        ncmp++; if (fetch_idle !== 1'b1) begin nerr++; $display("FAIL ar_idle got %b want 1", fetch_idle); end
        mq_addr.delete();
        mq_due.delete();
        alloc_m = 0;
        live = 1'b0;
        lat = 0;
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 15; i++) cycle();
        ncmp++; if (pop_pc.size() < 3) begin nerr++; $display("FAIL ar_pop_count got %0d want >=3", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            ncmp++; if (pop_pc[i] !== BASE + 64'(4 * i)) begin nerr++; $display("FAIL ar_pc[%0d] got %h want %h", i, pop_pc[i], BASE + 64'(4 * i)); end
        end
    endtask

    task automatic test_random();
        logic [63:0] exp_req;
        logic [63:0] exp_pop;
        int ri;
        int pi;
        bit redir;
        do_reset();
        exp_req = BASE;
        exp_pop = BASE;
        ri = 0;
        pi = 0;
        for (int n = 0; n < 600; n++) begin
            imem_req_ready = ($urandom_range(3) != 0);
            id_ready       = ($urandom_range(9) < 7);
            lat            = $urandom_range(3);
            redir          = ($urandom_range(24) == 0);
            redirect_valid = redir;
            redirect_pc    = {$urandom, $urandom};
            cycle();
            redirect_valid = 1'b0;
            if (redir) begin
                exp_req = {redirect_pc[63:2], 2'b00};
                exp_pop = exp_req;
            end
            while (ri < req_log.size()) begin
                ncmp++; if (req_log[ri] !== exp_req) begin nerr++; $display("FAIL rnd_req[%0d] got %h want %h", ri, req_log[ri], exp_req); end
                exp_req = exp_req + 64'd4;
                ri++;
            end
            while (pi < pop_pc.size()) begin
                ncmp++; if (pop_pc[pi] !== exp_pop || pop_inst[pi] !== mem_of(exp_pop)) begin nerr++; $display("FAIL rnd_pop[%0d] got %h/%h want %h/%h", pi, pop_pc[pi], pop_inst[pi], exp_pop, mem_of(exp_pop)); end
                exp_pop = exp_pop + 64'd4;
                pi++;
            end
        end
        ncmp++; if (pop_pc.size() < 50) begin nerr++; $display("FAIL rnd_pop_count got %0d want >=50", pop_pc.size()); end
        ncmp++; if (gate_err !== 0) begin nerr++; $display("FAIL req_gating got %0d bad cycles want 0", gate_err); end
        ncmp++; if (idle_err !== 0) begin nerr++; $display("FAIL idle_flag got %0d bad cycles want 0", idle_err); end
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        id_ready        = 1'b0;
        arm_pc          = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_req_stall();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
